ob_rsp_encoder: RTL

OB_RSP_ENCODER -- requirements
Module: ob_rsp_encoder

---
 rtl/ob_rsp_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ob_rsp_encoder.sv
// ============================================================================
// ob_pkg / ob_rsp_encoder
// Serialises queued response structs into byte frames:
// SOF marker, payload bytes (MSB first), XOR checksum.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ob_pkg;
  typedef struct packed {
    logic [1:0]  err;
    logic [3:0]  status;
    logic [7:0]  tag;
    logic [15:0] data;
  } rsp_t;
endpackage

module ob_rsp_encoder #(
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsp_in_vld,
  input  ob_pkg::rsp_t  rsp_in,
  output logic          rsp_in_pop,
  output logic          out_vld,
  output logic [7:0]    out_dat,
  input  logic          out_ack,
  output logic [15:0]   frames_sent_r,
  output logic          busy_r
);

  localparam int W       = $bits(ob_pkg::rsp_t);
  localparam int N       = (W + 7) / 8;
  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SOF     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [8*N-1:0]       r_frame;
  logic [c_IDX_W-1:0]   r_idx;
  logic [7:0]           r_csum;
  logic [7:0]           w_pay_byte;
  logic                 w_xfer;

  assign w_xfer = out_vld & out_ack;

  // Byte 0 of the frame payload is the most significant byte.
  always_comb begin
    w_pay_byte = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_pay_byte = r_frame[8*(N-1-i) +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    out_vld     = 1'b0;
    out_dat     = 8'h00;
    rsp_in_pop  = 1'b0;
    busy_r      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rsp_in_vld) begin
          rsp_in_pop  = 1'b1;
          w_state_nxt = SOF;
        end
      end
      SOF: begin
        out_vld = 1'b1;
        out_dat = SOF_BYTE;
        busy_r  = 1'b1;
        if (out_ack) begin
          w_state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        out_vld = 1'b1;
        out_dat = w_pay_byte;
        busy_r  = 1'b1;
        if (out_ack && (r_idx == c_LAST_IDX)) begin
          w_state_nxt = CSUM;
        end
      end
      CSUM: begin
        out_vld = 1'b1;
        out_dat = r_csum;
        busy_r  = 1'b1;
        if (out_ack) begin
          if (rsp_in_vld) begin
            rsp_in_pop  = 1'b1;
            w_state_nxt = SOF;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset masks every output combinationally so nothing leaks in the reset cycle.
    if (rst) begin
      w_state_nxt = IDLE;
      out_vld     = 1'b0;
      out_dat     = 8'h00;
      rsp_in_pop  = 1'b0;
      busy_r      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_csum        <= 8'h00;
      frames_sent_r <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (rsp_in_pop) begin
        r_csum <= 8'h00;
      end else if ((r_state == PAYLOAD) && w_xfer) begin
        r_csum <= r_csum ^ out_dat;
      end
      if ((r_state == SOF) && w_xfer) begin
        r_idx <= '0;
      end else if ((r_state == PAYLOAD) && w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if ((r_state == CSUM) && w_xfer) begin
        frames_sent_r <= frames_sent_r + 16'd1;
      end
    end
  end

  // Frame snapshot: decouples the frame in flight from the live queue head.
  always_ff @(posedge clk) begin
    if (rsp_in_pop) begin
      r_frame <= (8*N)'(rsp_in);
    end
  end

endmodule

`default_nettype wire
